// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM encoding and the default datapath width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_WORK = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider; div_by_zero exists only with SEQ_DIVIDER_DBZ_EN.
interface seq_divider_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
`ifdef SEQ_DIVIDER_DBZ_EN
  logic             div_by_zero;
`endif

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done
`ifdef SEQ_DIVIDER_DBZ_EN
    , input div_by_zero
`endif
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done
`ifdef SEQ_DIVIDER_DBZ_EN
    , output div_by_zero
`endif
  );
endinterface

// File: rtl/divider_step.sv
// One combinational non-restoring iteration on the {P,Q} pair; P carries a guard bit.
module divider_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH:0]   p,
  input  logic        [WIDTH-1:0] q,
  input  logic        [WIDTH-1:0] d,
  output logic signed [WIDTH:0]   p_next,
  output logic        [WIDTH-1:0] q_next
);
  logic signed [WIDTH:0] p_shift;
  logic signed [WIDTH:0] d_ext;

  always_comb begin
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    d_ext   = {1'b0, d};
    // Negative partial remainder adds the divisor back instead of restoring.
    if (p[WIDTH]) begin
      p_next = p_shift + d_ext;
    end else begin
      p_next = p_shift - d_ext;
    end
    q_next = {q[WIDTH-2:0], ~p_next[WIDTH]};
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: WIDTH non-restoring iterations on magnitudes, then a sign-fix cycle.
// Optional div_by_zero flag output is enabled by defining SEQ_DIVIDER_DBZ_EN.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic signed [WIDTH:0] p_q;
  logic [WIDTH-1:0]      q_q;
  logic [WIDTH-1:0]      d_q;
  logic [WIDTH-1:0]      a_q;
  logic                  neg_a_q;
  logic                  neg_q_q;
  logic                  dbz_q;
  logic [CW-1:0]         count_q;

  logic [WIDTH-1:0]      quotient_q;
  logic [WIDTH-1:0]      remainder_q;
  logic                  done_q;

  logic signed [WIDTH:0] p_step;
  logic [WIDTH-1:0]      q_step;
  logic [WIDTH-1:0]      a_mag;
  logic [WIDTH-1:0]      b_mag;
  logic [WIDTH-1:0]      p_fix;
  logic [WIDTH-1:0]      q_res;
  logic [WIDTH-1:0]      r_res;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_q),
    .q      (q_q),
    .d      (d_q),
    .p_next (p_step),
    .q_next (q_step)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (bus.start) state_d = DIV_WORK;
      DIV_WORK: if (count_q == LAST) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    // Most-negative operands wrap to 2^(WIDTH-1), which is the right unsigned magnitude.
    a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    b_mag = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    p_fix = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
    q_res = neg_q_q ? -q_q : q_q;
    r_res = neg_a_q ? -p_fix : p_fix;
    if (dbz_q) begin
      q_res = '1;
      r_res = a_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      a_q         <= '0;
      neg_a_q     <= 1'b0;
      neg_q_q     <= 1'b0;
      dbz_q       <= 1'b0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            q_q     <= a_mag;
            d_q     <= b_mag;
            a_q     <= bus.dividend;
            neg_a_q <= bus.dividend[WIDTH-1];
            neg_q_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            dbz_q   <= (bus.divisor == '0);
            p_q     <= '0;
            count_q <= '0;
          end
        end
        DIV_WORK: begin
          p_q     <= p_step;
          q_q     <= q_step;
          count_q <= count_q + CW'(1);
        end
        DIV_FIX: begin
          q_q <= q_res;
          p_q <= {r_res[WIDTH-1], r_res};
        end
        default: begin
          quotient_q  <= q_q;
          remainder_q <= p_q[WIDTH-1:0];
          done_q      <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEQ_DIVIDER_DBZ_EN
  logic dbz_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbz_out_q <= 1'b0;
    end else if (state_q == DIV_IDLE) begin
      dbz_out_q <= 1'b0;
    end else if (state_q == DIV_DONE) begin
      dbz_out_q <= dbz_q;
    end
  end

  assign bus.div_by_zero = dbz_out_q;
`endif

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.done      = done_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed integer divider; the inverse operation of the ALU's radix-4 Booth multiplier, with the same start/done handshake.
- Non-restoring algorithm on operand magnitudes, one quotient bit per cycle, followed by one correction/sign-fix cycle.
- Sits beside the multiplier in the ALU datapath.
- Produces a truncated-toward-zero quotient and a remainder whose sign matches the dividend.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured on the start edge.
- divisor  input  WIDTH  signed divisor; captured on the start edge.
- quotient  output  WIDTH  signed quotient (reg); held until the next result.
- remainder  output  WIDTH  signed remainder (reg); held until the next result.
- done  output  1  one-cycle result-valid pulse.
- div_by_zero  output  1  present only with SEQ_DIVIDER_DBZ_EN; valid while done is high.

Behaviour:
- Reset (async, any state): state=IDLE, and quotient, remainder, done, div_by_zero, count, internal registers are all 0.
- States: IDLE, WORK, FIX, DONE (2-bit encoding).
- IDLE:
  - done<=0 on every cycle.
  - When start=1: latch |dividend| into Q, |divisor| into D, the signs, and the divisor==0 flag; P (WIDTH+1-bit signed partial remainder)<=0; count<=0; go to WORK.
  - When start=0: stay in IDLE.
- WORK, one iteration per cycle:
  - Shift {P,Q} left by 1.
  - If the old P >= 0, then P = P - D; otherwise P = P + D.
  - New Q[0] = ~P_new[WIDTH].
  - count++.
  - Go to FIX when count == WIDTH-1.
- FIX:
  - If P < 0, then P = P + D.
  - Negate Q if the dividend and divisor signs differ.
  - Negate P if the dividend is negative.
  - Go to DONE.
- DONE: quotient<=Q, remainder<=P[WIDTH-1:0], done<=1; go to IDLE.
- Latency: fixed WIDTH+2 edges from the start-sampling edge to done rising. For WIDTH=8 this is 10 edges. done is high for exactly one cycle.
- start while not in IDLE is ignored. There is no queuing.
- start held high continuously: a new operation begins on the first IDLE cycle after done; operands are re-sampled at that point.
- Divide by zero: same latency. quotient = all ones (-1), remainder = dividend. The internal iteration result is discarded.
- Overflow (most-negative / -1): quotient = most-negative value (wraps), remainder = 0, no flag.
- Most-negative dividend: its magnitude is held as WIDTH-bit unsigned (e.g. 8'h80 = 128), which is correct.
- All arithmetic is two's complement. P carries one guard bit (WIDTH+1 bits). Negation is modulo 2^WIDTH.
- Reset mid-operation aborts the operation. No done is produced, and outputs clear to 0.

Optional Feature:
- Macro: SEQ_DIVIDER_DBZ_EN.
- Defined: div_by_zero port exists. It is registered in DONE alongside done (1 for a zero divisor, else 0), cleared in IDLE, and 0 on reset.
- Undefined: no port, no flag register. Quotient/remainder values for divide-by-zero are unchanged (-1, dividend).

Decomposition:
- Shared package alu_pkg:
  - State encoding constants IDLE=2'b00, WORK=2'b01, FIX=2'b10, DONE=2'b11 (distinct names from the multiplier's, e.g. DIV_IDLE...).
  - Default width constant ALU_WIDTH=8.
- Sub-module divider_step: combinational single non-restoring iteration.
  - Inputs: P, Q, D.
  - Outputs: P_next, Q_next.
  - Internally uses add/sub selected by P's sign bit.
  - FSM, counter and sign handling stay in seq_divider.

Test Plan:
- 100 / 7 -> quotient 14 (8'h0E), remainder 2; done high exactly one cycle, 10 edges after the start edge.
- -100 / 7 -> quotient -14 (8'hF2), remainder -2 (8'hFE). 100 / -7 -> quotient -14, remainder 2. -100 / -7 -> quotient 14, remainder -2 (8'hFE).
- -128 / -1 -> quotient 8'h80, remainder 0. -128 / 1 -> quotient 8'h80, remainder 0. 127 / 127 -> quotient 1, remainder 0. 5 / 9 -> quotient 0, remainder 5.
- 37 / 0 -> quotient 8'hFF, remainder 37 (8'h25), latency 10. With SEQ_DIVIDER_DBZ_EN, div_by_zero=1 with done. Next op 6 / 3 -> div_by_zero=0.
- start asserted on cycles 3 and 5 of an operation (50 / 5 busy) -> ignored; a single done with quotient 10, remainder 0.
- reset pulsed on the 4th WORK cycle -> done stays 0, outputs 0, state IDLE. Then start with -9 / 2 -> quotient -4 (8'hFC), remainder -1 (8'hFF).
